uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter TIMEOUT, default 4096, clk cycles allowed from tx_start to tx_done.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  N_REQ  per-requester byte pending.
REQ-006 req_data  input  8*N_REQ  per-requester byte; slice i = bits [8i+7:8i].
REQ-007 req_ready  output  N_REQ  one-hot, one-cycle pulse: byte of requester i captured.
REQ-008 req_done  output  N_REQ  one-hot, one-cycle pulse: requester i byte finished (sent or timed out).
REQ-009 tx_start  output  1  one-cycle pulse to the UART transmitter.
REQ-010 tx_data  output  8  byte to the transmitter; stable from tx_start until tx_done or timeout.
REQ-011 tx_done  input  1  one-cycle pulse from the transmitter: stop bit complete.
REQ-012 grant_id  output  clog2(N_REQ)  index of the current owner; valid while busy=1.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 error  output  1  one-cycle pulse on timeout.

Function
REQ-015 The FSM SHALL have states IDLE, START and WAIT_DONE.
REQ-016 IDLE: when any req_valid is high, select a winner round-robin starting at rr_ptr; capture req_data[winner] into tx_data; pulse req_ready[winner]; go to START.
REQ-017 START: assert tx_start for exactly one cycle; clear timeout counter; go to WAIT_DONE.
REQ-018 WAIT_DONE: on tx_done, pulse req_done[grant_id], set rr_ptr = grant_id+1 mod N_REQ, go to IDLE.
REQ-019 WAIT_DONE: when the counter reaches TIMEOUT-1 without tx_done, pulse error and req_done[grant_id], advance rr_ptr as in REQ-018, go to IDLE.
REQ-020 Latency: req_valid seen in IDLE -> req_ready next edge -> tx_start one cycle later.
REQ-021 Minimum spacing: tx_done -> IDLE -> next req_ready 1 cycle later, so two tx_start pulses are at least 3 cycles apart.
REQ-022 tx_done in IDLE or START SHALL be ignored.
REQ-023 tx_done and the timeout in the same cycle SHALL be treated as success (no error).
REQ-024 Requesters deasserting req_valid before req_ready SHALL lose no state; the arbiter does not latch requests.
REQ-025 rr_ptr wrap: pointer N_REQ-1 advances to 0; the search order is rr_ptr, rr_ptr+1, ... modulo N_REQ.
REQ-026 Only one requester SHALL own the transmitter at a time; req_ready and req_done are never multi-hot.

Reset
REQ-027 On rst: state IDLE, rr_ptr 0, counter 0, tx_data 8'h00, grant_id 0.
REQ-028 On rst: tx_start, req_ready, req_done, error, busy all 0.
REQ-029 Reset mid-transfer SHALL abandon the transfer with no req_done or error pulse.

Structure
REQ-030 A shared package uart_pkg SHALL hold the FSM state encoding and the default TIMEOUT constant.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter: inputs req and ptr; outputs one-hot grant and its index; purely combinational.
REQ-032 The timeout counter width SHALL be clog2(TIMEOUT)+1 and SHALL saturate; it never wraps.

Verification
REQ-033 Single request: req_valid[2]=1, data 8'hA5 -> req_ready[2] pulse, tx_start 1 cycle later with tx_data=A5; tx_done -> req_done[2], busy=0.
REQ-034 Fairness: all 4 valid continuously -> grant order 0,1,2,3,0; every req_done matches the preceding grant.
REQ-035 Timeout: TIMEOUT=16, tx_done never sent -> error and req_done pulse 16 cycles after tx_start; next grant goes to the following requester.
REQ-036 Same-cycle event: tx_done coincides with the timeout -> req_done pulses and error stays 0.
REQ-037 Reset in WAIT_DONE -> all outputs return to reset values next cycle; no req_done pulse; rr_ptr=0.
REQ-038 Stray tx_done in IDLE -> no output change; the following transfer completes normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and default timeout.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  // Cycles allowed between tx_start and tx_done before the transfer is abandoned.
  localparam int TIMEOUT_DEFAULT = 4096;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: searches i_ptr, i_ptr+1, ... modulo N_REQ
// and returns the first requester found as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  int   w_k;
  logic w_found;

  // Rotating priority search starting at the pointer.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_k     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_k = (int'(i_ptr) + i) % N_REQ;
      if (!w_found && i_req[w_k]) begin
        o_grant[w_k] = 1'b1;
        o_idx        = IW'(w_k);
        w_found      = 1'b1;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte requesters.
// Requests are not latched; a requester keeps req_valid high until req_ready.
//
// state        | meaning
// ST_IDLE      | transmitter free; grant the next valid requester
// ST_START     | byte captured, tx_start pulse issued on leaving this state
// ST_WAIT_DONE | waiting for tx_done, or abandon at the timeout
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         req_done,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  input  logic                     tx_done,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     error
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IW-1:0]    r_rr_ptr;
  logic [IW-1:0]    r_grant_id;
  logic [CW-1:0]    r_cnt;
  logic [7:0]       r_tx_data;
  logic [N_REQ-1:0] r_req_ready;
  logic [N_REQ-1:0] r_req_done;
  logic             r_tx_start;
  logic             r_error;

  logic [N_REQ-1:0] w_arb_grant;
  logic [IW-1:0]    w_arb_idx;
  logic             w_arb_any;
  logic [N_REQ-1:0] w_req_ready_nxt;
  logic [N_REQ-1:0] w_req_done_nxt;
  logic             w_tx_start_nxt;
  logic             w_error_nxt;
  logic             w_capture;
  logic             w_release;
  logic             w_timeout;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_arbiter (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_any   (w_arb_any)
  );

  assign w_timeout = (r_cnt >= CNT_LAST);

  // Next-state decode and next-cycle values of the single-cycle pulses.
  always_comb begin
    w_state_nxt     = r_state;
    w_req_ready_nxt = '0;
    w_req_done_nxt  = '0;
    w_tx_start_nxt  = 1'b0;
    w_error_nxt     = 1'b0;
    w_capture       = 1'b0;
    w_release       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_any) begin
          w_state_nxt     = ST_START;
          w_req_ready_nxt = w_arb_grant;
          w_capture       = 1'b1;
        end
      end
      ST_START: begin
        w_state_nxt    = ST_WAIT_DONE;
        w_tx_start_nxt = 1'b1;
      end
      ST_WAIT_DONE: begin
        // A tx_done arriving together with the timeout counts as success.
        if (tx_done || w_timeout) begin
          w_state_nxt                = ST_IDLE;
          w_req_done_nxt[r_grant_id] = 1'b1;
          w_error_nxt                = ~tx_done;
          w_release                  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Registered pulses, captured byte, current owner and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_ready <= '0;
      r_req_done  <= '0;
      r_tx_start  <= 1'b0;
      r_error     <= 1'b0;
      r_tx_data   <= 8'h00;
      r_grant_id  <= '0;
      r_rr_ptr    <= '0;
    end else begin
      r_req_ready <= w_req_ready_nxt;
      r_req_done  <= w_req_done_nxt;
      r_tx_start  <= w_tx_start_nxt;
      r_error     <= w_error_nxt;
      if (w_capture) begin
        r_tx_data  <= req_data[{w_arb_idx, 3'b000} +: 8];
        r_grant_id <= w_arb_idx;
      end
      if (w_release) begin
        r_rr_ptr <= (r_grant_id == IW'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;
      end
    end
  end

  // Timeout counter: cleared in START, saturating count while waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == ST_START) begin
      r_cnt <= '0;
    end else if (r_state == ST_WAIT_DONE && r_cnt != CNT_SAT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign req_ready = r_req_ready;
  assign req_done  = r_req_done;
  assign tx_start  = r_tx_start;
  assign tx_data   = r_tx_data;
  assign grant_id  = r_grant_id;
  assign error     = r_error;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter (N_REQ=4, TIMEOUT=16) against a cycle-level
// transaction model: free/granted/sending phases, round-robin by modular scan.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  req_done;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        busy;
  logic        error;

  int checks   = 0;
  int failures = 0;

  uart_tx_arbiter #(
    .N_REQ   (N),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .req_done  (req_done),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_done   (tx_done),
    .grant_id  (grant_id),
    .busy      (busy),
    .error     (error)
  );

  always #5 clk = ~clk;

  // model state
  int         m_ptr, ph, k, done_at, owner, n_grants, cyc;
  logic [7:0] cap;
  logic [3:0] e_ready, e_done;
  logic       e_start, e_err;
  // stimulus knobs
  logic [3:0]  cfg_valid;
  bit          cfg_rand_valid, cfg_stray, cfg_fix_data;
  logic [31:0] cfg_data;
  int          cfg_delay;
  // observations of the DUT
  int dut_log[$];
  int dut_errs, dut_done, last_start, last_err, last_done;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int winner(input logic [3:0] v, input int p);
    for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; ph = 0; k = 0; owner = 0;
    e_ready = '0; e_done = '0; e_start = 1'b0; e_err = 1'b0;
    last_start = -1;
  endtask

  task automatic do_reset();
    req_valid = '0; tx_done = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
  endtask

  // Check this cycle against the model, choose inputs, predict the next cycle.
  task automatic sim_cycles(input int ncyc, input int stop_grants);
    int ph_n, w, g0;
    bit hit;
    logic [3:0] v;
    logic [31:0] d;
    logic td;
    g0 = n_grants; hit = 0;
    for (int c = 0; c < ncyc; c++) begin
      checks++;
      if (req_ready !== e_ready) begin failures++; $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_ready); end
      checks++;
      if (tx_start !== e_start) begin failures++; $display("FAIL tx_start cyc=%0d got=%b exp=%b", cyc, tx_start, e_start); end
      checks++;
      if (req_done !== e_done) begin failures++; $display("FAIL req_done cyc=%0d got=%b exp=%b", cyc, req_done, e_done); end
      checks++;
      if (error !== e_err) begin failures++; $display("FAIL error cyc=%0d got=%b exp=%b", cyc, error, e_err); end
      checks++;
      if (busy !== (ph != 0)) begin failures++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, (ph != 0)); end
      if (ph != 0) begin
        checks++;
        if (grant_id !== 2'(owner)) begin failures++; $display("FAIL grant_id cyc=%0d got=%0d exp=%0d", cyc, grant_id, owner); end
        checks++;
        if (tx_data !== cap) begin failures++; $display("FAIL tx_data cyc=%0d got=%h exp=%h", cyc, tx_data, cap); end
      end
      if (tx_start === 1'b1) begin
        if (last_start >= 0) begin
          checks++;
          if (cyc - last_start < 3) begin failures++; $display("FAIL start_gap cyc=%0d got=%0d exp>=3", cyc, cyc - last_start); end
        end
        last_start = cyc;
      end
      if (req_ready !== 4'b0) dut_log.push_back(int'(grant_id));
      if (req_done !== 4'b0) begin dut_done++; last_done = cyc; end
      if (error === 1'b1) begin dut_errs++; last_err = cyc; end
      if (stop_grants > 0 && n_grants - g0 >= stop_grants && ph == 0) begin
        hit = 1;
        break;
      end

      v = cfg_rand_valid ? 4'($urandom_range(0, 15)) : cfg_valid;
      d = cfg_fix_data ? cfg_data : 32'($urandom);
      td = 1'b0; ph_n = ph;
      e_ready = '0; e_start = 1'b0; e_done = '0; e_err = 1'b0;
      case (ph)
        0: begin
          if (cfg_stray) td = 1'($urandom_range(0, 1));
          if (v != 4'b0) begin
            w = winner(v, m_ptr);
            owner = w; cap = d[8*w +: 8]; e_ready = 4'(1 << w);
            n_grants++; ph_n = 1;
          end
        end
        1: begin
          if (cfg_stray) td = 1'($urandom_range(0, 1));
          e_start = 1'b1; k = 0; ph_n = 2;
          done_at = (cfg_delay >= 0) ? cfg_delay : int'($urandom_range(0, 20));
        end
        default: begin
          td = (k == done_at);
          if (td || k == TO - 1) begin
            e_done = 4'(1 << owner); e_err = ~td;
            m_ptr = (owner + 1) % N; ph_n = 0;
          end else begin
            k++;
          end
        end
      endcase
      ph = ph_n;
      req_valid = v; req_data = d; tx_done = td;
      step(); cyc++;
    end
    if (hit) begin
      req_valid = '0; tx_done = 1'b0;
      e_ready = '0; e_start = 1'b0; e_done = '0; e_err = 1'b0;
      step(); cyc++;
    end
    if (stop_grants > 0) begin
      checks++;
      if (!hit) begin failures++; $display("FAIL grant_budget got=%0d exp=%0d", n_grants - g0, stop_grants); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; req_data = 32'hDEADBEEF; tx_done = 1'b1;
    step(); step();
    checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
    checks++; if (req_done !== 4'b0) begin failures++; $display("FAIL rst_req_done got=%b exp=0", req_done); end
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL rst_tx_start got=%b exp=0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL rst_tx_data got=%h exp=00", tx_data); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL rst_grant_id got=%0d exp=0", grant_id); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL rst_error got=%b exp=0", error); end
    req_valid = '0; tx_done = 1'b0; rst = 1'b0;
    model_reset();
    cfg_valid = '0; cfg_rand_valid = 0; cfg_stray = 0; cfg_fix_data = 0; cfg_delay = 0;
    sim_cycles(3, 0);
  endtask

  task automatic test_single();
    cfg_valid = 4'b0100; cfg_fix_data = 1; cfg_data = 32'h00A5_0000; cfg_delay = 3;
    sim_cycles(40, 1);
    checks++;
    if (dut_log.size() == 0 || dut_log[dut_log.size()-1] != 2) begin
      failures++; $display("FAIL single_grant got=%0d exp=2", dut_log.size() ? dut_log[dut_log.size()-1] : -1);
    end
    cfg_fix_data = 0;
  endtask

  task automatic test_fairness();
    int g0;
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    do_reset();
    g0 = dut_log.size();
    cfg_valid = 4'hF; cfg_delay = -1;
    sim_cycles(300, 5);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut_log.size() <= g0 + i || dut_log[g0 + i] != exp_seq[i]) begin
        failures++; $display("FAIL fair_order idx=%0d got=%0d exp=%0d", i, (dut_log.size() > g0 + i) ? dut_log[g0 + i] : -1, exp_seq[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int e0, d0;
    e0 = dut_errs; d0 = dut_done;
    cfg_valid = 4'b0010; cfg_delay = 99;
    sim_cycles(60, 1);
    checks++; if (dut_errs - e0 != 1) begin failures++; $display("FAIL to_err_count got=%0d exp=1", dut_errs - e0); end
    checks++; if (dut_done - d0 != 1) begin failures++; $display("FAIL to_done_count got=%0d exp=1", dut_done - d0); end
    checks++; if (last_err - last_start != TO) begin failures++; $display("FAIL to_latency got=%0d exp=%0d", last_err - last_start, TO); end
    cfg_valid = 4'hF; cfg_delay = 2;
    sim_cycles(40, 1);
    checks++;
    if (dut_log[dut_log.size()-1] != 2) begin failures++; $display("FAIL to_next_grant got=%0d exp=2", dut_log[dut_log.size()-1]); end
  endtask

  task automatic test_same_cycle();
    int e0, d0;
    e0 = dut_errs; d0 = dut_done;
    cfg_valid = 4'b1000; cfg_delay = TO - 1;
    sim_cycles(60, 1);
    checks++; if (dut_errs != e0) begin failures++; $display("FAIL same_err got=%0d exp=0", dut_errs - e0); end
    checks++; if (dut_done - d0 != 1) begin failures++; $display("FAIL same_done got=%0d exp=1", dut_done - d0); end
    checks++; if (last_done - last_start != TO) begin failures++; $display("FAIL same_latency got=%0d exp=%0d", last_done - last_start, TO); end
  endtask

  task automatic test_stray_done();
    int e0, d0;
    req_valid = '0; tx_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); cyc++;
      checks++;
      if ({req_ready, req_done, tx_start, error, busy} !== 11'b0) begin
        failures++; $display("FAIL stray_idle got=%b%b%b%b%b exp=0", req_ready, req_done, tx_start, error, busy);
      end
    end
    tx_done = 1'b0;
    e0 = dut_errs; d0 = dut_done;
    cfg_valid = 4'b0001; cfg_delay = 1;
    sim_cycles(40, 1);
    checks++; if (dut_done - d0 != 1 || dut_errs != e0) begin failures++; $display("FAIL stray_next done=%0d err=%0d exp=1/0", dut_done - d0, dut_errs - e0); end
  endtask

  task automatic test_reset_mid();
    int d0;
    cfg_valid = 4'b0010; cfg_delay = 99;
    sim_cycles(4, 0);
    d0 = dut_done;
    rst = 1'b1; req_valid = '0; tx_done = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
    checks++; if (tx_data !== 8'h00 || grant_id !== 2'd0) begin failures++; $display("FAIL mid_data got=%h/%0d exp=00/0", tx_data, grant_id); end
    step(); cyc++;
    checks++; if (req_done !== 4'b0 || error !== 1'b0) begin failures++; $display("FAIL mid_pulse got=%b/%b exp=0/0", req_done, error); end
    rst = 1'b0;
    model_reset();
    cfg_valid = 4'hF; cfg_delay = 0;
    sim_cycles(40, 1);
    checks++; if (dut_log[dut_log.size()-1] != 0) begin failures++; $display("FAIL mid_ptr got=%0d exp=0", dut_log[dut_log.size()-1]); end
    checks++; if (dut_done - d0 != 1) begin failures++; $display("FAIL mid_done got=%0d exp=1", dut_done - d0); end
  endtask

  task automatic test_random();
    int d0;
    do_reset();
    d0 = dut_done;
    cfg_rand_valid = 1; cfg_stray = 1; cfg_delay = -1;
    sim_cycles(1500, 0);
    checks++; if (dut_done - d0 < 20) begin failures++; $display("FAIL rand_progress got=%0d exp>=20", dut_done - d0); end
    cfg_rand_valid = 0; cfg_stray = 0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; tx_done = 1'b0;
    cyc = 0; n_grants = 0; dut_errs = 0; dut_done = 0;
    last_err = 0; last_done = 0;
    model_reset();
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_same_cycle();
    test_stray_done();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
